// File: rtl/alu_reg_sequencer.sv
// -----------------------------------------------------------------------------
// alu_reg_sequencer
//
// Purpose:
//   Multi-cycle control unit for the ALU/register datapath. It fetches an
//   8-bit instruction byte from the instruction ROM and decodes it. It then
//   sequences the per-cycle control words for the datapath: destination
//   write, B-bus source, register increment, RAM read/write, ALU operation
//   and Z-flag update. It also handles RAM wait states and conditional jumps
//   on the datapath Z flag.
//
// Ports:
//   clk              in   1  system clock, rising edge
//   rst              in   1  synchronous active-high reset
//   start            in   1  1-cycle pulse; leaves IDLE/DONE and starts fetching
//   step             in   1  (ALU_REG_SEQ_STEP_EN only) release from PAUSE
//   INS_BUS          in   8  instruction byte at current PC (combinational ROM)
//   Z                in   1  datapath zero flag
//   C_Control        out  6  destination write select, 0 = no write
//   B_Control        out  3  B-bus source select
//   REG_INC          out  3  register increment select, 0 = none
//   M                out  2  M[1] = RAM read, M[0] = RAM write
//   ALU_sig          out  4  ALU operation
//   Control_Signal_Z out  1  Z-flag update enable
//   busy             out  1  high in every state except IDLE/DONE
//   done             out  1  high in DONE
//   illegal_op       out  1  1-cycle pulse in DECODE on an undefined opcode
//   o_dbg_state      out  3  current FSM state, for observation only
//
// Optional feature (macro ALU_REG_SEQ_STEP_EN):
//   Adds the step input and a PAUSE state. Every return to FETCH after an
//   instruction goes through PAUSE instead. PAUSE waits there until step=1.
//
// Handshake: start is a single-cycle pulse. It is only honoured in IDLE or
// DONE and ignored while busy. There is no back-pressure on any output.
// -----------------------------------------------------------------------------
module alu_reg_sequencer #(
   parameter int unsigned MEM_LAT = 2,      // RAM access length, 1..15
   parameter logic [5:0]  C_AC    = 6'd1,
   parameter logic [5:0]  C_PC    = 6'd2,
   parameter logic [2:0]  B_DR    = 3'd7,
   parameter logic [2:0]  INC_PC  = 3'd1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef ALU_REG_SEQ_STEP_EN
   input  logic       step,
`endif
   input  logic [7:0] INS_BUS,
   input  logic       Z,
   output logic [5:0] C_Control,
   output logic [2:0] B_Control,
   output logic [2:0] REG_INC,
   output logic [1:0] M,
   output logic [3:0] ALU_sig,
   output logic       Control_Signal_Z,
   output logic       busy,
   output logic       done,
   output logic       illegal_op,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEMW   = 3'd4,
      ST_OPER   = 3'd5,
      ST_DONE   = 3'd6
`ifdef ALU_REG_SEQ_STEP_EN
      , ST_PAUSE = 3'd7
`endif
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_LDM  = 4'h2;
   localparam logic [3:0] OP_STM  = 4'h3;
   localparam logic [3:0] OP_MOV  = 4'h4;
   localparam logic [3:0] OP_JZ   = 4'h5;
   localparam logic [3:0] OP_JNZ  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Wait counter start value. MEM_LAT=1 loads 0, which gives a single MEMW cycle.
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_ir;
   logic [3:0] r_wait;

   logic [3:0] w_op;
   logic       w_taken;
   logic       w_last_mem;
   state_t     w_resume;

   assign w_op       = r_ir[7:4];
   assign w_last_mem = (r_wait == 4'd0);
   // Z is sampled combinationally during the OPER cycle.
   assign w_taken    = (w_op == OP_JMP) ||
                       ((w_op == OP_JZ)  &&  Z) ||
                       ((w_op == OP_JNZ) && !Z);

   // After an instruction completes, the FSM goes back to FETCH. In step
   // mode it goes to PAUSE instead.
`ifdef ALU_REG_SEQ_STEP_EN
   assign w_resume = ST_PAUSE;
`else
   assign w_resume = ST_FETCH;
`endif

   assign o_dbg_state = r_state;

   // State, instruction register and wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ir    <= 8'h00;
         r_wait  <= 4'd0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_FETCH) begin
            r_ir <= INS_BUS;
         end
         // Loading in every DECODE is harmless. Only MEMW reads the count.
         if (r_state == ST_DECODE) begin
            r_wait <= LAT_M1;
         end else if ((r_state == ST_MEMW) && !w_last_mem) begin
            r_wait <= r_wait - 4'd1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next = ST_FETCH;
         ST_FETCH:  w_next = ST_DECODE;
         ST_DECODE: begin
            case (w_op)
               OP_NOP:                 w_next = w_resume;
               OP_ALU, OP_MOV:         w_next = ST_EXEC;
               OP_LDM, OP_STM:         w_next = ST_MEMW;
               OP_JZ, OP_JNZ, OP_JMP:  w_next = ST_OPER;
               OP_HALT:                w_next = ST_DONE;
               default:                w_next = w_resume;  // illegal acts as NOP
            endcase
         end
         ST_EXEC:   w_next = w_resume;
         ST_MEMW:   if (w_last_mem) w_next = w_resume;
         ST_OPER:   w_next = w_resume;
         ST_DONE:   if (start) w_next = ST_FETCH;
`ifdef ALU_REG_SEQ_STEP_EN
         ST_PAUSE:  if (step) w_next = ST_FETCH;
`endif
         default:   w_next = ST_IDLE;
      endcase
   end

   // Moore output decode: outputs depend on the state and IR. In OPER they
   // also depend on the Z flag.
   always_comb begin
      C_Control        = 6'd0;
      B_Control        = 3'd0;
      REG_INC          = 3'd0;
      M                = 2'b00;
      ALU_sig          = 4'd0;
      Control_Signal_Z = 1'b0;
      busy             = 1'b1;
      done             = 1'b0;
      illegal_op       = 1'b0;
      case (r_state)
         ST_IDLE:  busy = 1'b0;
         ST_FETCH: REG_INC = INC_PC;
         ST_DECODE: begin
            illegal_op = !((w_op <= OP_JMP) || (w_op == OP_HALT));
         end
         ST_EXEC: begin
            B_Control = r_ir[2:0];
            C_Control = C_AC;
            if (w_op == OP_ALU) begin
               ALU_sig          = r_ir[3:0];
               Control_Signal_Z = 1'b1;
            end
         end
         ST_MEMW: begin
            if (w_op == OP_LDM) begin
               M = 2'b10;
               // The last wait cycle captures the RAM data into the accumulator.
               if (w_last_mem) begin
                  B_Control = B_DR;
                  C_Control = C_AC;
               end
            end else begin
               M = 2'b01;
            end
         end
         ST_OPER: begin
            if (w_taken) C_Control = C_PC;
            else         REG_INC   = INC_PC;   // skip the target byte
         end
         ST_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_reg_sequencer
//
// Self-checking bench for alu_reg_sequencer. The bench keeps its own program
// counter and a 256-byte ROM. It plays the role of the datapath: it drives
// INS_BUS from the ROM at the model PC. For each instruction it derives the
// expected control word for every cycle from the instruction's opcode.
// Directed programs run first, then a long random program with random Z and
// stray start pulses. Define ALU_REG_SEQ_STEP_EN for both DUT and bench to
// exercise the PAUSE/step mode.
// -----------------------------------------------------------------------------
module tb_alu_reg_sequencer;

   localparam int unsigned MEM_LAT = 3;
   localparam logic [5:0]  C_AC    = 6'd1;
   localparam logic [5:0]  C_PC    = 6'd2;
   localparam logic [2:0]  B_DR    = 3'd7;
   localparam logic [2:0]  INC_PC  = 3'd1;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       step;
   logic [7:0] INS_BUS;
   logic       Z;
   logic [5:0] C_Control;
   logic [2:0] B_Control;
   logic [2:0] REG_INC;
   logic [1:0] M;
   logic [3:0] ALU_sig;
   logic       Control_Signal_Z;
   logic       busy;
   logic       done;
   logic       illegal_op;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   alu_reg_sequencer #(
      .MEM_LAT(MEM_LAT), .C_AC(C_AC), .C_PC(C_PC), .B_DR(B_DR), .INC_PC(INC_PC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
`ifdef ALU_REG_SEQ_STEP_EN
      .step(step),
`endif
      .INS_BUS(INS_BUS),
      .Z(Z),
      .C_Control(C_Control),
      .B_Control(B_Control),
      .REG_INC(REG_INC),
      .M(M),
      .ALU_sig(ALU_sig),
      .Control_Signal_Z(Control_Signal_Z),
      .busy(busy),
      .done(done),
      .illegal_op(illegal_op),
      .o_dbg_state(dbg_state)
   );

   logic [21:0] obs;
   assign obs = {C_Control, B_Control, REG_INC, M, ALU_sig,
                 Control_Signal_Z, busy, done, illegal_op};

   // ---------------- reference model state ----------------
   logic [7:0] rom [256];
   logic [7:0] pc;
   int         n_tests = 0;
   int         n_fail  = 0;

   // Expected control word, packed in the same order as obs.
   function automatic logic [21:0] mk(input logic [5:0] c, input logic [2:0] b,
                                      input logic [2:0] inc, input logic [1:0] m,
                                      input logic [3:0] alu, input logic ze,
                                      input logic bsy, input logic dn,
                                      input logic ill);
      return {c, b, inc, m, alu, ze, bsy, dn, ill};
   endfunction

   // ---------------- scoreboard check ----------------
   task automatic check_eq(input string tag, input logic [21:0] got,
                           input logic [21:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h (pc=%h)", tag, $time, got, exp, pc);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Inputs change 1 time unit after the rising edge. Outputs are compared on
   // the falling edge.
   task automatic cyc(input logic [7:0] ins, input logic z, input logic st,
                      input logic rs, input logic stp, input logic [21:0] exp,
                      input string tag);
      INS_BUS = ins;
      Z       = z;
      start   = st;
      rst     = rs;
      step    = stp;
      @(negedge clk);
      check_eq(tag, obs, exp);
      @(posedge clk);
      #1;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [7:0] rand_op();
      logic [3:0] lo;
      lo = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 11))
         0:       return {4'h0, lo};
         1, 2:    return {4'h1, lo};
         3:       return {4'h2, lo};
         4:       return {4'h3, lo};
         5:       return {4'h4, lo};
         6:       return {4'h5, lo};
         7:       return {4'h6, lo};
         8:       return {4'h7, lo};
         9:       return {4'($urandom_range(8, 14)), lo};
         10:      return {4'hF, lo};
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Cycles between instructions in step mode. PAUSE shows only busy.
   task automatic pause_cycles();
`ifdef ALU_REG_SEQ_STEP_EN
      int k;
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++)
         cyc(rom[pc], rbit(), rbit(), 1'b0, 1'b0, mk(0,0,0,0,0,0,1,0,0), "pause_hold");
      cyc(rom[pc], rbit(), rbit(), 1'b0, 1'b1, mk(0,0,0,0,0,0,1,0,0), "pause_step");
`endif
   endtask

   // Run one instruction, starting from its FETCH cycle.
   //   zm: 0/1 forces Z during OPER, 2 picks Z at random.
   //   rst_mid: for an LDM, reset during the second wait cycle.
   task automatic run_instr(input int zm, input bit rst_mid);
      logic [7:0] op;
      logic [3:0] hi;
      logic       ill;
      logic       z;
      logic       taken;
      logic [21:0] e;
      int          k;
      op  = rom[pc];
      hi  = op[7:4];
      ill = (hi >= 4'h8) && (hi != 4'hF);
      cyc(rom[pc], rbit(), rbit(), 1'b0, 1'b0, mk(0,0,INC_PC,0,0,0,1,0,0), "fetch");
      pc = pc + 8'd1;
      cyc(rom[pc], rbit(), rbit(), 1'b0, 1'b0, mk(0,0,0,0,0,0,1,0,ill), "decode");
      case (hi)
         4'h1: cyc(rom[pc], rbit(), rbit(), 1'b0, 1'b0,
                   mk(C_AC, op[2:0], 0, 0, op[3:0], 1, 1, 0, 0), "exec_alu");
         4'h4: cyc(rom[pc], rbit(), rbit(), 1'b0, 1'b0,
                   mk(C_AC, op[2:0], 0, 0, 0, 0, 1, 0, 0), "exec_mov");
         4'h2, 4'h3: begin
            for (int i = 0; i < int'(MEM_LAT); i++) begin
               if (hi == 4'h3)                e = mk(0, 0, 0, 2'b01, 0, 0, 1, 0, 0);
               else if (i == int'(MEM_LAT)-1) e = mk(C_AC, B_DR, 0, 2'b10, 0, 0, 1, 0, 0);
               else                           e = mk(0, 0, 0, 2'b10, 0, 0, 1, 0, 0);
               if (rst_mid && hi == 4'h2 && i == 1) begin
                  cyc(rom[pc], rbit(), 1'b0, 1'b1, 1'b0, e, "rst_in_memw");
                  cyc(rom[pc], rbit(), 1'b0, 1'b1, 1'b0, 22'd0, "rst_held");
                  cyc(rom[pc], rbit(), 1'b0, 1'b0, 1'b0, 22'd0, "idle_after_rst");
                  cyc(rom[pc], rbit(), 1'b1, 1'b0, 1'b0, 22'd0, "idle_start");
                  return;
               end
               cyc(rom[pc], rbit(), rbit(), 1'b0, 1'b0, e, hi == 4'h2 ? "memw_ldm" : "memw_stm");
            end
         end
         4'h5, 4'h6, 4'h7: begin
            z     = (zm == 2) ? rbit() : zm[0];
            taken = (hi == 4'h7) || (hi == 4'h5 && z) || (hi == 4'h6 && !z);
            if (taken) e = mk(C_PC, 0, 0, 0, 0, 0, 1, 0, 0);
            else       e = mk(0, 0, INC_PC, 0, 0, 0, 1, 0, 0);
            cyc(rom[pc], z, rbit(), 1'b0, 1'b0, e, taken ? "oper_taken" : "oper_skip");
            if (taken) pc = rom[pc];
            else       pc = pc + 8'd1;
         end
         4'hF: begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++)
               cyc(rom[pc], rbit(), 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,1,0), "done_hold");
            cyc(rom[pc], rbit(), 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,1,0), "done_start");
            return;   // DONE goes straight to FETCH, never via PAUSE
         end
         default: ;   // NOP and illegal opcodes end after DECODE
      endcase
      pause_cycles();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 256; i++) rom[i] = rand_op();
      // Directed program
      rom[8'h00] = 8'h13;  rom[8'h01] = 8'hF0;
      rom[8'h02] = 8'h20;  rom[8'h03] = 8'h30;
      rom[8'h04] = 8'h50;  rom[8'h05] = 8'h40;   // JZ, Z=1 -> 0x40
      rom[8'h40] = 8'h50;  rom[8'h41] = 8'h10;   // JZ, Z=0 -> skip to 0x42
      rom[8'h42] = 8'h60;  rom[8'h43] = 8'h20;   // JNZ, Z=1 -> skip to 0x44
      rom[8'h44] = 8'h60;  rom[8'h45] = 8'h46;   // JNZ, Z=0 -> 0x46
      rom[8'h46] = 8'hA5;                        // illegal
      rom[8'h47] = 8'h2C;                        // LDM, reset mid-access
      pc = 8'h00;

      INS_BUS = 8'h00; Z = 1'b0; start = 1'b0; step = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      cyc(rom[pc], 1'b0, 1'b0, 1'b1, 1'b0, 22'd0, "reset_state");
      cyc(rom[pc], 1'b0, 1'b0, 1'b0, 1'b0, 22'd0, "idle_quiet");
      cyc(rom[pc], 1'b0, 1'b1, 1'b0, 1'b0, 22'd0, "idle_start");

      run_instr(2, 1'b0);   // 0x13 ALU
      run_instr(2, 1'b0);   // 0xF0 HALT, then restart
      run_instr(2, 1'b0);   // 0x20 LDM
      run_instr(2, 1'b0);   // 0x30 STM
      run_instr(1, 1'b0);   // JZ taken
      run_instr(0, 1'b0);   // JZ not taken
      run_instr(1, 1'b0);   // JNZ not taken
      run_instr(0, 1'b0);   // JNZ taken
      run_instr(2, 1'b0);   // 0xA5 illegal
      run_instr(2, 1'b1);   // LDM interrupted by reset; PC stays at 0x48
      if (pc != 8'h48) begin
         n_tests++;
         n_fail++;
         $display("FAIL pc_after_rst: got %h expected 48", pc);
      end

      // Random program: random Z, stray start pulses, occasional reset in an LDM
      for (int n = 0; n < 400; n++)
         run_instr(2, ($urandom_range(0, 15) == 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
